// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: sequences fetch/decode/execute/writeback
// over a shared memory and ALU, driving every datapath select and enable.
module multicycle_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zeroFlag,
  input  logic       signFlag,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    LUI      = 4'd11,
    HALT     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] A_ADD = 3'b000;
  localparam logic [2:0] A_SLL = 3'b001;
  localparam logic [2:0] A_SUB = 3'b010;
  localparam logic [2:0] A_XOR = 3'b100;
  localparam logic [2:0] A_SRL = 3'b101;
  localparam logic [2:0] A_OR  = 3'b110;
  localparam logic [2:0] A_AND = 3'b111;

  state_t state;
  state_t next;

  logic [2:0] alu_fn;
  logic       fn_ok;
  logic       taken;
  logic       is_r;

  assign is_r = (op == OP_R);

  always_ff @(posedge clk) begin
    if (reset)
      state <= state_t'(RESET_STATE);
    else
      state <= next;
  end

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_SW:   ImmSrc = 3'b001;
      OP_B:    ImmSrc = 3'b010;
      OP_JAL:  ImmSrc = 3'b011;
      OP_LUI:  ImmSrc = 3'b100;
      default: ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    alu_fn = A_ADD;
    fn_ok  = 1'b1;
    case (funct3)
      3'b000:  alu_fn = (is_r && funct7b5) ? A_SUB : A_ADD;
      3'b001:  alu_fn = A_SLL;
      3'b100:  alu_fn = A_XOR;
      3'b101: begin
        alu_fn = A_SRL;
        fn_ok  = !funct7b5;
      end
      3'b110:  alu_fn = A_OR;
      3'b111:  alu_fn = A_AND;
      default: fn_ok = 1'b0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zeroFlag;
      3'b001:  taken = !zeroFlag;
      3'b100:  taken = signFlag;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next       = FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = A_ADD;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        next      = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):  next = MEMADR;
          (op == OP_R):   next = fn_ok ? EXECUTER : HALT;
          (op == OP_I):   next = fn_ok ? EXECUTEI : HALT;
          (op == OP_B):   next = BRANCH;
          (op == OP_JAL): next = JAL;
          (op == OP_LUI): next = LUI;
          default:        next = HALT;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        next    = (op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        next   = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        next      = FETCH;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        next     = FETCH;
      end
      EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = alu_fn;
        next       = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_fn;
        next       = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        next     = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = A_SUB;
        PCWrite    = taken;
        next       = FETCH;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        next    = ALUWB;
      end
      LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        next    = ALUWB;
      end
      HALT: begin
        illegal = 1'b1;
        next    = HALT;
      end
      default: next = FETCH;
    endcase
    if (reset) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b10;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b10;
      ALUControl = A_ADD;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: table of instructions, expected
// per-cycle control words queued and compared against the DUT.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zeroFlag;
  logic       signFlag;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zeroFlag(zeroFlag), .signFlag(signFlag),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] imm;
    logic [2:0] alu;
    logic       ill;
  } ov_t;

  typedef enum {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXR, S_EXI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_HALT
  } tst_t;

  typedef enum {C_LW, C_SW, C_R, C_I, C_BR, C_JAL, C_LUI, C_HALT} cls_t;

  typedef struct {
    string      nm;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zf;
    logic       sf;
    cls_t       cls;
    logic [2:0] alu;
    logic       taken;
  } vec_t;

  ov_t act;
  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};

  ov_t q[$];
  int  checks = 0;
  int  errors = 0;
  vec_t tbl [21];

  function automatic logic [2:0] exp_imm(logic [6:0] o);
    case (o)
      7'b0000011, 7'b0010011: return 3'b000;
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b0110111:             return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic ov_t exp_vec(tst_t s, logic [6:0] o,
                                  logic [2:0] alu, logic tk);
    ov_t e;
    e = '0;
    e.imm = exp_imm(o);
    case (s)
      S_FETCH: begin
        e.pcw = 1; e.irw = 1; e.srcb = 2'b10; e.res = 2'b10;
      end
      S_DECODE:   begin e.srca = 2'b01; e.srcb = 2'b01; end
      S_MEMADR:   begin e.srca = 2'b10; e.srcb = 2'b01; end
      S_MEMREAD:  e.adr = 1;
      S_MEMWB:    begin e.res = 2'b01; e.regw = 1; end
      S_MEMWRITE: begin e.adr = 1; e.memw = 1; end
      S_EXR:      begin e.srca = 2'b10; e.alu = alu; end
      S_EXI: begin
        e.srca = 2'b10; e.srcb = 2'b01; e.alu = alu;
      end
      S_ALUWB:    e.regw = 1;
      S_BRANCH: begin
        e.srca = 2'b10; e.alu = 3'b010; e.pcw = tk;
      end
      S_JAL: begin
        e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1;
      end
      S_LUI:      begin e.srca = 2'b11; e.srcb = 2'b01; end
      S_HALT:     e.ill = 1;
      default:    e.ill = 0;
    endcase
    return e;
  endfunction

  function automatic ov_t rst_vec(logic [6:0] o);
    ov_t e;
    e = '0;
    e.imm  = exp_imm(o);
    e.srcb = 2'b10;
    e.res  = 2'b10;
    return e;
  endfunction

  function automatic tst_t seq_state(cls_t c, int k);
    if (k == 0) return S_FETCH;
    if (k == 1) return S_DECODE;
    case (c)
      C_LW:    return (k == 2) ? S_MEMADR :
                      (k == 3) ? S_MEMREAD : S_MEMWB;
      C_SW:    return (k == 2) ? S_MEMADR : S_MEMWRITE;
      C_R:     return (k == 2) ? S_EXR : S_ALUWB;
      C_I:     return (k == 2) ? S_EXI : S_ALUWB;
      C_JAL:   return (k == 2) ? S_JAL : S_ALUWB;
      C_LUI:   return (k == 2) ? S_LUI : S_ALUWB;
      C_BR:    return S_BRANCH;
      default: return S_HALT;
    endcase
  endfunction

  function automatic int cls_len(cls_t c);
    case (c)
      C_LW:    return 5;
      C_BR:    return 3;
      C_HALT:  return 12;
      default: return 4;
    endcase
  endfunction

  task automatic check(string nm);
    ov_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", nm, act);
      return;
    end
    e = q.pop_front();
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  task automatic drive(vec_t v);
    op = v.op; funct3 = v.f3; funct7b5 = v.f7;
    zeroFlag = v.zf; signFlag = v.sf;
  endtask

  task automatic run_seq(vec_t v, int n);
    tst_t s;
    for (int k = 0; k < n; k++) begin
      s = seq_state(v.cls, k);
      q.push_back(exp_vec(s, v.op, v.alu, v.taken));
      @(negedge clk);
      check($sformatf("%s c%0d %s", v.nm, k, s.name()));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_cycle(string nm);
    reset = 1'b1;
    #1;
    q.push_back(rst_vec(op));
    @(negedge clk);
    check(nm);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  vec_t h;

  initial begin
    tbl[0]  = '{"lw",   7'b0000011, 3'b010, 0, 0, 0, C_LW,  3'b000, 0};
    tbl[1]  = '{"sw",   7'b0100011, 3'b010, 0, 0, 0, C_SW,  3'b000, 0};
    tbl[2]  = '{"add",  7'b0110011, 3'b000, 0, 0, 0, C_R,   3'b000, 0};
    tbl[3]  = '{"sub",  7'b0110011, 3'b000, 1, 0, 0, C_R,   3'b010, 0};
    tbl[4]  = '{"xor",  7'b0110011, 3'b100, 0, 0, 0, C_R,   3'b100, 0};
    tbl[5]  = '{"and",  7'b0110011, 3'b111, 0, 0, 0, C_R,   3'b111, 0};
    tbl[6]  = '{"or",   7'b0110011, 3'b110, 0, 0, 0, C_R,   3'b110, 0};
    tbl[7]  = '{"srl",  7'b0110011, 3'b101, 0, 0, 0, C_R,   3'b101, 0};
    tbl[8]  = '{"sll",  7'b0110011, 3'b001, 0, 0, 0, C_R,   3'b001, 0};
    tbl[9]  = '{"addi", 7'b0010011, 3'b000, 1, 0, 0, C_I,   3'b000, 0};
    tbl[10] = '{"srli", 7'b0010011, 3'b101, 0, 0, 0, C_I,   3'b101, 0};
    tbl[11] = '{"xori", 7'b0010011, 3'b100, 0, 0, 0, C_I,   3'b100, 0};
    tbl[12] = '{"beqT", 7'b1100011, 3'b000, 0, 1, 0, C_BR,  3'b000, 1};
    tbl[13] = '{"beqN", 7'b1100011, 3'b000, 0, 0, 1, C_BR,  3'b000, 0};
    tbl[14] = '{"bneN", 7'b1100011, 3'b001, 0, 1, 0, C_BR,  3'b000, 0};
    tbl[15] = '{"bneT", 7'b1100011, 3'b001, 0, 0, 0, C_BR,  3'b000, 1};
    tbl[16] = '{"bltT", 7'b1100011, 3'b100, 0, 0, 1, C_BR,  3'b000, 1};
    tbl[17] = '{"bltN", 7'b1100011, 3'b100, 0, 1, 0, C_BR,  3'b000, 0};
    tbl[18] = '{"bge",  7'b1100011, 3'b101, 0, 1, 1, C_BR,  3'b000, 0};
    tbl[19] = '{"jal",  7'b1101111, 3'b000, 0, 0, 0, C_JAL, 3'b000, 0};
    tbl[20] = '{"lui",  7'b0110111, 3'b000, 0, 0, 0, C_LUI, 3'b000, 0};

    reset = 1'b1;
    drive(tbl[0]);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      q.push_back(rst_vec(op));
      @(negedge clk);
      check($sformatf("reset%0d", i));
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i]);
      run_seq(tbl[i], cls_len(tbl[i].cls));
    end

    h = '{"halt_fence", 7'b0001111, 3'b000, 0, 0, 0, C_HALT, 3'b000, 0};
    drive(h);
    run_seq(h, cls_len(h.cls));
    reset_cycle("halt_fence_rst");

    h = '{"halt_srai", 7'b0010011, 3'b101, 1, 0, 0, C_HALT, 3'b000, 0};
    drive(h);
    run_seq(h, cls_len(h.cls));
    reset_cycle("halt_srai_rst");

    h = '{"halt_slt", 7'b0110011, 3'b010, 0, 1, 1, C_HALT, 3'b000, 0};
    drive(h);
    run_seq(h, cls_len(h.cls));
    reset_cycle("halt_slt_rst");

    drive(tbl[19]);
    run_seq(tbl[19], 4);

    drive(tbl[0]);
    run_seq(tbl[0], 3);
    reset_cycle("lw_abort_rst");
    run_seq(tbl[0], 5);

    drive(tbl[1]);
    run_seq(tbl[1], 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle control unit for the RV32 core: the instruction-side producer of the ALU's ALUControl code and the consumer of its zeroFlag/signFlag outputs.
- Sequences each instruction through fetch/decode/execute/writeback states over a single shared memory and a single ALU.
- Drives every datapath mux select and write enable.
- Sits between the instruction register (op/funct fields) and the datapath.

Parameters:
- RESET_STATE, 4'd0, state encoding loaded on reset (FETCH); must stay 0.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- op  input  7  instr[6:0] from the instruction register
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- zeroFlag  input  1  ALU result == 0
- signFlag  input  1  ALU result[31]
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register / OldPC enable
- RegWrite  output  1  register file write enable
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALUResult
- ALUSrcA  output  2  A operand select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- ALUSrcB  output  2  B operand select: 00 = rs2, 01 = immediate, 10 = constant 4
- ImmSrc  output  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- ALUControl  output  3  ALU op: 000 = add, 001 = sll, 010 = sub, 100 = xor, 101 = srl, 110 = or, 111 = and
- illegal  output  1  high while halted on an unsupported instruction

Behaviour:
- State register: 4 bits, updated on the clk rising edge; reset → FETCH. Reset asserted mid-instruction abandons that instruction.
- Output timing: all outputs are combinational from the state and the op/funct inputs. No output depends on the flags except PCWrite in BRANCH.
- Reset values: while reset is high, PCWrite, MemWrite, IRWrite and RegWrite are forced to 0 and illegal is 0. The other outputs show their FETCH values.
- ImmSrc is decoded from op in every state:
  - lw / addi-group → 000
  - sw → 001
  - branch → 010
  - jal → 011
  - lui → 100
  - other → 000
- Defaults in every state unless listed: all enables 0, AdrSrc = 0, ResultSrc = 00, ALUSrcA = 00, ALUSrcB = 00, ALUControl = 000.
- State table (outputs; next state):
  - FETCH: IRWrite = 1, PCWrite = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, add, ResultSrc = 10; next DECODE.
  - DECODE: ALUSrcA = 01, ALUSrcB = 01, add (branch target into ALUOut). Next state by op:
    - lw 0000011 / sw 0100011 → MEMADR
    - R 0110011 → EXECUTER
    - I 0010011 → EXECUTEI
    - B 1100011 → BRANCH
    - jal 1101111 → JAL
    - lui 0110111 → LUI
    - else → HALT
  - MEMADR: ALUSrcA = 10, ALUSrcB = 01, add; next MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD: AdrSrc = 1; next MEMWB.
  - MEMWB: ResultSrc = 01, RegWrite = 1; next FETCH.
  - MEMWRITE: AdrSrc = 1, MemWrite = 1; next FETCH.
  - EXECUTER: ALUSrcA = 10, ALUSrcB = 00, ALUControl = funct decode; next ALUWB.
  - EXECUTEI: ALUSrcA = 10, ALUSrcB = 01, ALUControl = funct decode; next ALUWB.
  - ALUWB: ResultSrc = 00, RegWrite = 1; next FETCH.
  - BRANCH: ALUSrcA = 10, ALUSrcB = 00, sub, ResultSrc = 00. PCWrite = 1 when taken:
    - beq (funct3 000): zeroFlag
    - bne (001): !zeroFlag
    - blt (100): signFlag; the sign of the difference only, no overflow correction
    - other funct3: never taken
    - next FETCH.
  - JAL: ALUSrcA = 01, ALUSrcB = 10, add, ResultSrc = 00, PCWrite = 1; next ALUWB.
  - LUI: ALUSrcA = 11, ALUSrcB = 01, add; next ALUWB.
  - HALT: illegal = 1, all enables 0; stays in HALT until reset.
- Funct decode for ALUControl (funct3 → code):
  - 000 → add; but sub (010) when R-type and funct7b5 = 1
  - 001 → sll
  - 100 → xor
  - 101 → srl
  - 110 → or
  - 111 → and
- Unsupported funct combinations (funct3 010/011, sra/srai with funct7b5 = 1 and funct3 101) → DECODE goes to HALT instead of the execute state.
- Cycle counts:
  - lw: 5
  - sw: 4
  - R-type / I-type / jal / lui: 4
  - branch: 3
- Unencoded state values → next state FETCH, all enables 0.

Test Plan:
- Reset for 2 cycles with op = lw → enables 0 during reset. First cycle after reset is FETCH with IRWrite = 1, PCWrite = 1, ALUSrcB = 10; then DECODE.
- lw (op 0000011) → 5-cycle sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite = 1 and ResultSrc = 01 only in cycle 5.
- R-type sub (funct3 000, funct7b5 1) → ALUControl = 010 in EXECUTER. Same with funct7b5 0 → 000. xor → 100, and → 111.
- beq with zeroFlag = 1 → PCWrite = 1 in BRANCH. bne with zeroFlag = 1 → PCWrite = 0. blt with signFlag = 1 → PCWrite = 1. Each returns to FETCH after 3 cycles.
- jal → PCWrite = 1 with ALUSrcA = 01 in JAL, then RegWrite = 1 in ALUWB. lui → ALUSrcA = 11, ImmSrc = 100.
- op 0001111, or srai (funct3 101, funct7b5 1) → HALT, illegal = 1 held 10 cycles, all enables 0. Reset → FETCH, illegal = 0.
